// File: rtl/draw_pkg.sv
// Shared types and screen constants for the drawing engines and their sequencer.
package draw_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Wide enough to hold the largest per-phase cycle budget (65536 - 1).
    localparam int WD_W = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_GAP,
        S_CIRC,
        S_FIN,
        S_ERR
    } seq_state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
        logic           plot;
    } plot_t;

    // True in the states where an engine owns the plot port.
    function automatic logic is_engine_phase(seq_state_t s);
        return (s == S_FILL) || (s == S_CIRC);
    endfunction

endpackage

// File: rtl/draw_sequencer_plot_mux.sv
// Registered 2-to-1 plot-stream mux; loads an all-zero plot word when idle.
module plot_mux
    import draw_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           sel_b,
    input  logic           idle,
    input  logic [X_W-1:0] a_x,
    input  logic [Y_W-1:0] a_y,
    input  logic [C_W-1:0] a_colour,
    input  logic           a_plot,
    input  logic [X_W-1:0] b_x,
    input  logic [Y_W-1:0] b_y,
    input  logic [C_W-1:0] b_colour,
    input  logic           b_plot,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic [C_W-1:0] out_colour,
    output logic           out_plot
);

    plot_t a_s;
    plot_t b_s;
    plot_t out_d;
    plot_t out_q;

    assign a_s = {a_x, a_y, a_colour, a_plot};
    assign b_s = {b_x, b_y, b_colour, b_plot};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        out_d = '0;
        if (!idle) begin
            out_d = sel_b ? b_s : a_s;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_x      = out_q.x;
    assign out_y      = out_q.y;
    assign out_colour = out_q.colour;
    assign out_plot   = out_q.plot;

endmodule

// File: rtl/draw_sequencer.sv
// Runs the fill engine then the circle engine on one shared, registered VGA plot port,
// with a per-phase watchdog that aborts a phase whose engine never reports done.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int TIMEOUT = 65536
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           done,
    output logic           error,
    output logic           busy,
    input  logic [C_W-1:0] bg_colour,
    input  logic [C_W-1:0] fg_colour,

    output logic           fill_start,
    input  logic           fill_done,
    output logic [C_W-1:0] fill_colour,
    input  logic [X_W-1:0] fill_vga_x,
    input  logic [Y_W-1:0] fill_vga_y,
    input  logic [C_W-1:0] fill_vga_colour,
    input  logic           fill_vga_plot,

    output logic           circ_start,
    input  logic           circ_done,
    output logic [C_W-1:0] circ_colour,
    input  logic [X_W-1:0] circ_vga_x,
    input  logic [Y_W-1:0] circ_vga_y,
    input  logic [C_W-1:0] circ_vga_colour,
    input  logic           circ_vga_plot,

    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_colour,
    output logic           vga_plot
);

    localparam logic [WD_W-1:0] WD_TERM = WD_W'(TIMEOUT - 1);

    seq_state_t      state_q;
    seq_state_t      state_d;
    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                    wd_d    = '0;
                end
            end
            S_FILL: begin
                wd_d = wd_q + WD_W'(1);
                // Dropping start aborts first; a done on the terminal count still wins.
                if (!start) begin
                    state_d = S_IDLE;
                end else if (fill_done) begin
                    state_d = S_GAP;
                end else if (wd_q == WD_TERM) begin
                    state_d = S_ERR;
                end
            end
            S_GAP: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CIRC;
                    wd_d    = '0;
                end
            end
            S_CIRC: begin
                wd_d = wd_q + WD_W'(1);
                if (!start) begin
                    state_d = S_IDLE;
                end else if (circ_done) begin
                    state_d = S_FIN;
                end else if (wd_q == WD_TERM) begin
                    state_d = S_ERR;
                end
            end
            S_FIN, S_ERR: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    // Handshake and status outputs decode straight from state so they drop with it.
    assign fill_start  = (state_q == S_FILL);
    assign circ_start  = (state_q == S_CIRC);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN) || (state_q == S_ERR);
    assign error       = (state_q == S_ERR);
    assign fill_colour = bg_colour;
    assign circ_colour = fg_colour;

    plot_mux u_plot_mux (
        .clk        (clk),
        .rst        (rst),
        .sel_b      (state_q == S_CIRC),
        .idle       (!is_engine_phase(state_q)),
        .a_x        (fill_vga_x),
        .a_y        (fill_vga_y),
        .a_colour   (fill_vga_colour),
        .a_plot     (fill_vga_plot),
        .b_x        (circ_vga_x),
        .b_y        (circ_vga_y),
        .b_colour   (circ_vga_colour),
        .b_plot     (circ_vga_plot),
        .out_x      (vga_x),
        .out_y      (vga_y),
        .out_colour (vga_colour),
        .out_plot   (vga_plot)
    );

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: two instances (default watchdog and TIMEOUT=16) driven by
// behavioural engine models and checked every cycle against a cycle-count phase model.
module tb_draw_sequencer;

    localparam int N     = 2;
    localparam int NEVER = 1 << 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] bg = 3'b010;
    logic [2:0] fg = 3'b101;

    logic       fill_start [N];
    logic       fill_done  [N];
    logic [2:0] fill_colour[N];
    logic [7:0] fvx        [N];
    logic [6:0] fvy        [N];
    logic [2:0] fvc        [N];
    logic       fvp        [N];
    logic       circ_start [N];
    logic       circ_done  [N];
    logic [2:0] circ_colour[N];
    logic [7:0] cvx        [N];
    logic [6:0] cvy        [N];
    logic [2:0] cvc        [N];
    logic       cvp        [N];
    logic       done_o     [N];
    logic       error_o    [N];
    logic       busy_o     [N];
    logic [7:0] vga_x      [N];
    logic [6:0] vga_y      [N];
    logic [2:0] vga_colour [N];
    logic       vga_plot   [N];

    // Model state: a[i] = cycles since the IDLE->FILL edge (0 = idle).
    int          a        [N];
    int          fl       [N];
    int          cl       [N];
    int          cprob    [N];
    int          fcnt     [N];
    int          ccnt     [N];
    int          plots    [N];
    logic [18:0] prev_fill[N];
    logic [18:0] prev_circ[N];
    logic [18:0] exp_vga  [N];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    draw_sequencer dut0 (
        .clk(clk), .rst(rst), .start(start), .done(done_o[0]), .error(error_o[0]), .busy(busy_o[0]),
        .bg_colour(bg), .fg_colour(fg),
        .fill_start(fill_start[0]), .fill_done(fill_done[0]), .fill_colour(fill_colour[0]),
        .fill_vga_x(fvx[0]), .fill_vga_y(fvy[0]), .fill_vga_colour(fvc[0]), .fill_vga_plot(fvp[0]),
        .circ_start(circ_start[0]), .circ_done(circ_done[0]), .circ_colour(circ_colour[0]),
        .circ_vga_x(cvx[0]), .circ_vga_y(cvy[0]), .circ_vga_colour(cvc[0]), .circ_vga_plot(cvp[0]),
        .vga_x(vga_x[0]), .vga_y(vga_y[0]), .vga_colour(vga_colour[0]), .vga_plot(vga_plot[0])
    );

    draw_sequencer #(.TIMEOUT(16)) dut1 (
        .clk(clk), .rst(rst), .start(start), .done(done_o[1]), .error(error_o[1]), .busy(busy_o[1]),
        .bg_colour(bg), .fg_colour(fg),
        .fill_start(fill_start[1]), .fill_done(fill_done[1]), .fill_colour(fill_colour[1]),
        .fill_vga_x(fvx[1]), .fill_vga_y(fvy[1]), .fill_vga_colour(fvc[1]), .fill_vga_plot(fvp[1]),
        .circ_start(circ_start[1]), .circ_done(circ_done[1]), .circ_colour(circ_colour[1]),
        .circ_vga_x(cvx[1]), .circ_vga_y(cvy[1]), .circ_vga_colour(cvc[1]), .circ_vga_plot(cvp[1]),
        .vga_x(vga_x[1]), .vga_y(vga_y[1]), .vga_colour(vga_colour[1]), .vga_plot(vga_plot[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int timeout_of(int i);
        return (i == 0) ? 65536 : 16;
    endfunction

    // Phase from elapsed cycles: 0 idle, 1 fill, 2 gap, 3 circ, 4 fin, 5 err.
    function automatic int phase(int aa, int f, int c, int t);
        int k;
        if (aa == 0) return 0;
        if (f > t) return (aa <= t) ? 1 : 5;
        if (aa <= f) return 1;
        if (aa == f + 1) return 2;
        k = aa - f - 1;
        if (c > t) return (k <= t) ? 3 : 5;
        if (k <= c) return 3;
        return 4;
    endfunction

    task automatic tick();
        int p;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            p = phase(a[i], fl[i], cl[i], timeout_of(i));
            if (rst) begin
                exp_vga[i] = '0;
                a[i]       = 0;
            end else begin
                exp_vga[i] = (p == 1) ? prev_fill[i] : (p == 3) ? prev_circ[i] : 19'd0;
                a[i]       = start ? a[i] + 1 : 0;
            end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            p = phase(a[i], fl[i], cl[i], timeout_of(i));
            check($sformatf("fill_start[%0d]", i), 32'(fill_start[i]), 32'(p == 1));
            check($sformatf("circ_start[%0d]", i), 32'(circ_start[i]), 32'(p == 3));
            check($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(p != 0));
            check($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(p == 4 || p == 5));
            check($sformatf("error[%0d]", i), 32'(error_o[i]), 32'(p == 5));
            check($sformatf("vga[%0d]", i), 32'({vga_x[i], vga_y[i], vga_colour[i], vga_plot[i]}),
                  32'(exp_vga[i]));
            check($sformatf("fill_colour[%0d]", i), 32'(fill_colour[i]), 32'(bg));
            check($sformatf("circ_colour[%0d]", i), 32'(circ_colour[i]), 32'(fg));
            if (vga_plot[i] === 1'b1) plots[i]++;

            // Fill engine: raster-order pixels while started, garbage otherwise.
            if (fill_start[i] === 1'b1) begin
                fvx[i]       = 8'(fcnt[i] % 160);
                fvy[i]       = 7'((fcnt[i] / 160) % 120);
                fvc[i]       = bg;
                fvp[i]       = 1'b1;
                fill_done[i] = (fcnt[i] == fl[i] - 1);
                fcnt[i]++;
            end else begin
                fcnt[i]      = 0;
                fvx[i]       = 8'($urandom);
                fvy[i]       = 7'($urandom);
                fvc[i]       = 3'($urandom);
                fvp[i]       = 1'($urandom);
                fill_done[i] = 1'b0;
            end
            // Circle engine: random points while started, garbage (including plots) otherwise.
            if (circ_start[i] === 1'b1) begin
                cvx[i]       = 8'($urandom_range(159));
                cvy[i]       = 7'($urandom_range(119));
                cvc[i]       = fg;
                cvp[i]       = ($urandom_range(99) < cprob[i]);
                circ_done[i] = (ccnt[i] == cl[i] - 1);
                ccnt[i]++;
            end else begin
                ccnt[i]      = 0;
                cvx[i]       = 8'($urandom);
                cvy[i]       = 7'($urandom);
                cvc[i]       = 3'($urandom);
                cvp[i]       = 1'($urandom);
                circ_done[i] = 1'b0;
            end
            prev_fill[i] = {fvx[i], fvy[i], fvc[i], fvp[i]};
            prev_circ[i] = {cvx[i], cvy[i], cvc[i], cvp[i]};
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            a[i] = 0; fcnt[i] = 0; ccnt[i] = 0; plots[i] = 0;
            fill_done[i] = 1'b0; circ_done[i] = 1'b0;
            fvx[i] = '0; fvy[i] = '0; fvc[i] = '0; fvp[i] = 1'b0;
            cvx[i] = '0; cvy[i] = '0; cvc[i] = '0; cvp[i] = 1'b0;
            prev_fill[i] = '0; prev_circ[i] = '0; exp_vga[i] = '0;
        end

        // Full run: reset held with start high, then 19200 fill + 500 circle cycles.
        fl[0] = 19200; cl[0] = 500; cprob[0] = 100;
        fl[1] = NEVER; cl[1] = 10;  cprob[1] = 50;
        bg = 3'b010; fg = 3'($urandom);
        rst = 1'b1; start = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        plots[0] = 0;
        tick();
        check("fill_after_rst", 32'(fill_start[0]), 32'd1);
        tick();
        check("first_plot", 32'({vga_x[0], vga_y[0], vga_colour[0], vga_plot[0]}),
              32'({8'd0, 7'd0, 3'b010, 1'b1}));
        repeat (19703) tick();
        check("seq_done", 32'(done_o[0]), 32'd1);
        check("wd_err", 32'(error_o[1]), 32'd1);
        check("plot_count", 32'(plots[0]), 32'd19700);
        start = 1'b0;
        tick();
        check("err_clear", 32'(error_o[1]), 32'd0);
        repeat (2) tick();

        // Abort mid-circle at plot 100; dut1 has done coinciding with its terminal count.
        fl[0] = $urandom_range(200, 20); cl[0] = 500; cprob[0] = 100;
        fl[1] = 16; cl[1] = 16; cprob[1] = 70;
        fg = 3'($urandom);
        start = 1'b1;
        for (int n = 0; n < 400 && a[0] < fl[0] + 101; n++) tick();
        check("abort_point", 32'(a[0]), 32'(fl[0] + 101));
        start = 1'b0;
        tick();
        check("abort_circ_start", 32'(circ_start[0]), 32'd0);
        tick();
        check("abort_no_plot", 32'(vga_plot[0]), 32'd0);
        start = 1'b1;
        tick();
        check("restart_fill", 32'(fill_start[0]), 32'd1);

        // Reset mid-fill with start held high.
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check("rst_busy", 32'(busy_o[0]), 32'd0);
        check("rst_vga_plot", 32'(vga_plot[0]), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_refill", 32'(fill_start[0]), 32'd1);
        start = 1'b0;
        repeat (2) tick();

        // Randomised runs: short phases, watchdog hits, random aborts and resets.
        for (int r = 0; r < 60; r++) begin
            fl[0] = $urandom_range(60, 1);
            cl[0] = $urandom_range(60, 1);
            fl[1] = ($urandom_range(7) == 0) ? NEVER : $urandom_range(24, 1);
            cl[1] = $urandom_range(24, 1);
            cprob[0] = $urandom_range(100);
            cprob[1] = $urandom_range(100);
            bg = 3'($urandom);
            fg = 3'($urandom);
            start = 1'b1;
            repeat ($urandom_range(150, 1)) tick();
            if ($urandom_range(5) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                repeat ($urandom_range(20, 1)) tick();
            end
            start = 1'b0;
            repeat ($urandom_range(3, 1)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Top-level controller that shares the single VGA plot port between the fill-screen engine and the circle engine. It runs them back to back: clear the screen in `bg_colour`, then draw the circle in `fg_colour`. It drives each engine's start/done handshake, multiplexes their plot streams onto one registered VGA port, and aborts a phase through a watchdog if an engine never reports done. It sits between the task top level (switches/keys) and the VGA adapter core.

## Interface
Parameters:
- `TIMEOUT`, default 65536: maximum cycles allowed per engine phase before the sequencer aborts.

Ports:
- `clk`  in  1  system clock (50 MHz); one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; hold high until `done`.
- `done`  out  1  sequence finished, or aborted on error.
- `error`  out  1  watchdog abort occurred.
- `busy`  out  1  high in any state except IDLE.
- `bg_colour`  in  3  fill colour.
- `fg_colour`  in  3  circle colour.
- `fill_start`  out  1  to fill engine.
- `fill_done`  in  1  from fill engine.
- `fill_colour`  out  3  equals `bg_colour`.
- `fill_vga_x` / `fill_vga_y` / `fill_vga_colour` / `fill_vga_plot`  in  8/7/3/1  fill engine plot stream.
- `circ_start`  out  1  to circle engine.
- `circ_done`  in  1  from circle engine.
- `circ_colour`  out  3  equals `fg_colour`.
- `circ_vga_x` / `circ_vga_y` / `circ_vga_colour` / `circ_vga_plot`  in  8/7/3/1  circle engine plot stream.
- `vga_x` / `vga_y` / `vga_colour` / `vga_plot`  out  8/7/3/1  registered, to the VGA adapter.

## Operation
- States: IDLE, FILL, GAP, CIRC, FIN, ERR.
- IDLE: `start` = 1 -> FILL.
- FILL: `fill_start` = 1. On `fill_done` = 1 -> GAP.
- GAP: one cycle with both engine starts low, so the fill engine returns to its reset state. Then -> CIRC.
- CIRC: `circ_start` = 1. On `circ_done` = 1 -> FIN.
- FIN: `done` = 1 while `start` = 1. When `start` = 0 -> IDLE.
- ERR: `done` = 1 and `error` = 1 while `start` = 1. When `start` = 0 -> IDLE. `error` clears on leaving ERR.
- Abort: `start` = 0 in FILL, GAP or CIRC -> IDLE on the next edge. Engine starts drop that cycle (they are decoded from state). No plot is issued after that.
- Watchdog: a 17-bit phase counter, wide enough for `TIMEOUT`.
  - Cleared on entry to FILL and to CIRC; increments every cycle in those states.
  - If it reaches `TIMEOUT`-1 without the matching done -> ERR.
  - `done` wins if it coincides with the terminal count.
- Mux:
  - Sources: fill stream in FILL, circle stream in CIRC.
  - In all other states, the registered outputs load x = 0, y = 0, colour = 0, plot = 0.
  - Plot from the inactive engine is always ignored.
- Engine starts, `done`, `error` and `busy` are combinational from state. Only the VGA outputs are registered.

## Timing
- Reset: state IDLE; `vga_x` = 0, `vga_y` = 0, `vga_colour` = 0, `vga_plot` = 0; `done`, `error`, `busy`, `fill_start`, `circ_start` all 0; phase counter 0.
- `rst` overrides everything, including mid-phase. The engine starts are low in the cycle after the reset edge.
- `start` is sampled at the edge: edge k IDLE→FILL, so `fill_start` is high from cycle k+1.
- VGA latency: exactly one cycle. Engine plot at cycle t appears on `vga_*` at t+1, gated by the state at t.
- Phase hand-off: `fill_done` sampled high at edge m. Then GAP in cycle m+1, CIRC and `circ_start` from m+2.
- A `vga_plot` = 1 appears at cycle m+1 only if the fill engine plotted in its done cycle. `vga_plot` is 0 at cycle m+2 (GAP).
- `done` rises in the cycle after `circ_done` is sampled.

## Structure
- Shared package `draw_pkg`:
  - state enum `seq_state_t`.
  - constants `X_W` = 8, `Y_W` = 7, `C_W` = 3, `SCREEN_W` = 160, `SCREEN_H` = 120.
  - This package is reused by the engines.
- Sub-module `plot_mux`: a registered 2-to-1 plot-stream mux with select and an idle-zero input. It is the only sub-module.

## Test plan
- Reset with `start` = 1, release -> FILL next cycle; `fill_start` = 1; all `vga_*` = 0 during reset.
- Engine models: fill done after 19200 cycles, circle done after 500 cycles -> exactly 19200 fill plots then 500 circle plots on `vga_*`, each delayed one cycle. The first plot is (0,0) with colour `bg_colour` = 3'b010. `done` = 1 in the cycle after `circ_done`.
- Circle engine asserts plot during FILL -> no `vga_plot` from it. GAP cycle shows `vga_plot` = 0 and both starts low.
- `TIMEOUT` = 16 and `fill_done` never rises -> ERR after 16 FILL cycles; `done` = `error` = 1; drop `start` -> IDLE with `error` = 0.
- Drop `start` mid-CIRC at plot 100 -> IDLE next edge; `circ_start` = 0; no `vga_plot` after a one-cycle tail. Restart -> begins again in FILL.
- Assert `rst` mid-FILL -> IDLE next edge with all outputs at their reset values, even though `start` stays high.
